// File: rtl/calc_1.sv
// Four independent two-cycle arithmetic channels (add, subtract, optional shifts).
// Define CALC1_SHIFT_EN to enable the shift commands 5 and 6.
module calc_1 (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  typedef enum logic {IDLE, OP2} state_t;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  // Only reset[1] is functional; the remaining bits are deliberately ignored.
  logic rst_n;
  logic unused_reset_bits;
  assign rst_n             = reset[1];
  assign unused_reset_bits = ^reset[2:7];

  // Bit 0 of each [0:N] port is the MSB, so plain assignment keeps numeric value.
  logic [3:0]  cmd_in   [4];
  logic [31:0] data_in  [4];
  logic [31:0] data_out [4];
  logic [1:0]  resp_out [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_data1 = data_out[0];
  assign out_data2 = data_out[1];
  assign out_data3 = data_out[2];
  assign out_data4 = data_out[3];
  assign out_resp1 = resp_out[0];
  assign out_resp2 = resp_out[1];
  assign out_resp3 = resp_out[2];
  assign out_resp4 = resp_out[3];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      state_t      state_reg, state_next;
      logic [3:0]  cmd_reg,   cmd_next;
      logic [31:0] op1_reg,   op1_next;
      logic [31:0] data_reg,  data_next;
      logic [1:0]  resp_reg,  resp_next;
      logic [32:0] sum;
      logic [31:0] diff;

      // Operand 2 is consumed straight from the input at the second edge.
      assign sum  = {1'b0, op1_reg} + {1'b0, data_in[gi]};
      assign diff = op1_reg - data_in[gi];

      always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        op1_next   = op1_reg;
        data_next  = '0;
        resp_next  = RESP_NONE;
        case (state_reg)
          IDLE: begin
            if (cmd_in[gi] != CMD_NOP) begin
              state_next = OP2;
              cmd_next   = cmd_in[gi];
              op1_next   = data_in[gi];
            end
          end
          OP2: begin
            state_next = IDLE;
            resp_next  = RESP_ERR;
            case (cmd_reg)
              CMD_ADD: begin
                if (!sum[32]) begin
                  resp_next = RESP_OK;
                  data_next = sum[31:0];
                end
              end
              CMD_SUB: begin
                if (data_in[gi] <= op1_reg) begin
                  resp_next = RESP_OK;
                  data_next = diff;
                end
              end
`ifdef CALC1_SHIFT_EN
              CMD_SHL: begin
                resp_next = RESP_OK;
                data_next = op1_reg << data_in[gi][4:0];
              end
              CMD_SHR: begin
                resp_next = RESP_OK;
                data_next = op1_reg >> data_in[gi][4:0];
              end
`endif
              default: ;
            endcase
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge c_clk) begin
        if (!rst_n) begin
          state_reg <= IDLE;
          cmd_reg   <= '0;
          op1_reg   <= '0;
          data_reg  <= '0;
          resp_reg  <= RESP_NONE;
        end else begin
          state_reg <= state_next;
          cmd_reg   <= cmd_next;
          op1_reg   <= op1_next;
          data_reg  <= data_next;
          resp_reg  <= resp_next;
        end
      end

      assign data_out[gi] = data_reg;
      assign resp_out[gi] = resp_reg;
    end
  endgenerate

endmodule

// File: tb/tb_calc_1.sv
// Scoreboard bench for calc_1: stimulus pushes expected results, a monitor pops and checks.
module tb_calc_1;

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [0:3]  cmd_a  [4];
  logic [0:31] data_a [4];
  logic [0:31] od     [4];
  logic [0:1]  orr    [4];

  always #5 c_clk = ~c_clk;

  calc_1 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_a[0]),
    .req1_data_in (data_a[0]),
    .req2_cmd_in  (cmd_a[1]),
    .req2_data_in (data_a[1]),
    .req3_cmd_in  (cmd_a[2]),
    .req3_data_in (data_a[2]),
    .req4_cmd_in  (cmd_a[3]),
    .req4_data_in (data_a[3]),
    .out_data1    (od[0]),
    .out_resp1    (orr[0]),
    .out_data2    (od[1]),
    .out_resp2    (orr[1]),
    .out_data3    (od[2]),
    .out_resp3    (orr[2]),
    .out_data4    (od[3]),
    .out_resp4    (orr[3])
  );

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  logic [3:0]  st_cmd [4];
  logic [31:0] st_op1 [4];
  logic [31:0] st_op2 [4];
  logic [1:0]  st_er  [4];
  logic [31:0] st_ed  [4];

  always @(posedge c_clk) cyc <= cyc + 1;

  // Monitor: any nonzero response must match the oldest pending entry for that port.
  always @(negedge c_clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        if (orr[p] == 2'd0) begin
          checks++;
          if (od[p] != 32'd0) begin
            errors++;
            $display("FAIL idle_data port%0d cyc%0d: got data=%h, need 00000000", p + 1, cyc, od[p]);
          end
        end else begin
          int idx;
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].port == p) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_resp port%0d cyc%0d: got resp=%0d data=%h, need no response",
                     p + 1, cyc, orr[p], od[p]);
          end else begin
            if (sb[idx].cyc != cyc || orr[p] != sb[idx].resp || od[p] != sb[idx].data) begin
              errors++;
              $display("FAIL result port%0d: got cyc%0d resp=%0d data=%h, need cyc%0d resp=%0d data=%h",
                       p + 1, cyc, orr[p], od[p], sb[idx].cyc, sb[idx].resp, sb[idx].data);
            end else begin
              $display("port%0d cyc%0d resp=%0d data=%h ok", p + 1, cyc, orr[p], od[p]);
            end
            sb.delete(idx);
          end
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_resp port%0d: got nothing at cyc%0d, need resp=%0d data=%h",
                   sb[i].port + 1, sb[i].cyc, sb[i].resp, sb[i].data);
          sb.delete(i);
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the result edge so commands can chain.
  task automatic fire();
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = st_cmd[p];
      data_a[p] = st_op1[p];
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      if (st_cmd[p] != 4'd0) begin
        sb.push_back('{p, st_er[p], st_ed[p], cyc + 1});
        cmd_a[p] = 4'hB;  // garbage command during operand-2 cycle must be ignored
      end else begin
        cmd_a[p] = 4'd0;
      end
      data_a[p] = st_op2[p];
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd0;
      data_a[p] = 32'd0;
      st_cmd[p] = 4'd0;
    end
  endtask

  task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    st_cmd[p] = c;
    st_op1[p] = a;
    st_op2[p] = b;
    st_er[p]  = er;
    st_ed[p]  = ed;
  endtask

  // Shift expectations depend on whether the shift feature is built in.
  task automatic set_shift(input int p, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ed);
`ifdef CALC1_SHIFT_EN
    set_port(p, c, a, b, 2'd1, ed);
`else
    set_port(p, c, a, b, 2'd2, 32'd0);
`endif
  endtask

  task automatic one(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] er, input logic [31:0] ed);
    set_port(0, c, a, b, er, ed);
    fire();
  endtask

  task automatic one_sh(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed);
    set_shift(0, c, a, b, ed);
    fire();
  endtask

  initial begin
    reset = 7'b0111111;
    for (int p = 0; p < 4; p++) begin
      cmd_a[p]  = 4'd0;
      data_a[p] = 32'd0;
      st_cmd[p] = 4'd0;
    end
    @(posedge c_clk); #1;
    mon_en = 1'b1;
    // Commands presented while in reset must be ignored.
    cmd_a[0] = 4'd1; data_a[0] = 32'h5;
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd0; data_a[0] = 32'd0;
    @(posedge c_clk); #1;
    reset = 7'b1000000;

    one(4'd1, 32'h00000001, 32'h01FFFFFF, 2'd1, 32'h02000000);
    one(4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h0);
    one(4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE);
    one(4'd1, 32'hFFFFFFFF, 32'h00000000, 2'd1, 32'hFFFFFFFF);
    one(4'd2, 32'h00000001, 32'h0000000F, 2'd2, 32'h0);
    one(4'd2, 32'h0000000F, 32'h00000001, 2'd1, 32'h0000000E);
    one(4'd2, 32'h00000005, 32'h00000005, 2'd1, 32'h0);
    one(4'd3, 32'h00000001, 32'h00000000, 2'd2, 32'h0);
    one(4'd4, 32'h00000001, 32'h00000000, 2'd2, 32'h0);
    one(4'd7, 32'h00000009, 32'h00000002, 2'd2, 32'h0);
    one(4'd15, 32'h00000009, 32'h00000002, 2'd2, 32'h0);
    repeat (2) @(posedge c_clk);
    #1;
    one_sh(4'd5, 32'h80000001, 32'h00000021, 32'h00000002);
    one_sh(4'd6, 32'h80000000, 32'h0000001F, 32'h00000001);
    one_sh(4'd5, 32'h0000ABCD, 32'h00000000, 32'h0000ABCD);

    for (int k = 0; k <= 30; k++) one(4'd1, 32'd1 << k, 32'd0, 2'd1, 32'd1 << k);
    for (int k = 0; k <= 29; k++) one_sh(4'd5, 32'd1 << k, 32'd1, 32'd1 << (k + 1));

    set_port(0, 4'd1, 32'h11111111, 32'h22222222, 2'd1, 32'h33333333);
    set_port(1, 4'd2, 32'h00000050, 32'h00000020, 2'd1, 32'h00000030);
    set_shift(2, 4'd5, 32'h00000003, 32'h00000004, 32'h00000030);
    set_port(3, 4'd9, 32'h00000001, 32'h00000001, 2'd2, 32'h0);
    fire();
    set_port(0, 4'd2, 32'h00000002, 32'h00000003, 2'd2, 32'h0);
    set_port(1, 4'd1, 32'h80000000, 32'h80000000, 2'd2, 32'h0);
    set_shift(2, 4'd6, 32'h000000F0, 32'h00000024, 32'h0000000F);
    set_port(3, 4'd1, 32'h00000007, 32'h00000008, 2'd1, 32'h0000000F);
    fire();

    // Reset during the operand-2 cycle aborts the command without a response.
    cmd_a[0] = 4'd1; data_a[0] = 32'h3;
    @(posedge c_clk); #1;
    reset = 7'b0111111;
    cmd_a[0] = 4'd0; data_a[0] = 32'h4;
    @(posedge c_clk); #1;
    cmd_a[0] = 4'd1; data_a[0] = 32'h7;
    @(posedge c_clk); #1;
    reset = 7'b1000000;
    one(4'd1, 32'h00000010, 32'h00000020, 2'd1, 32'h00000030);

    repeat (3) @(posedge c_clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending_at_end: got %0d outstanding results, need 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_1.md
CALC_1 -- requirements
Module: calc_1

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed.
REQ-002 c_clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  7 ([1:7])  reset is synchronous and active-low; only reset[1] is functional, reset[2:7] are ignored.
REQ-004 reqN_cmd_in  input  4 ([0:3]) per port N=1..4  command code, bit 0 MSB.
REQ-005 reqN_data_in  input  32 ([0:31]) per port N=1..4  operand 1 in command cycle, operand 2 in following cycle; bit 0 MSB.
REQ-006 out_dataN  output  32 ([0:31]) per port N=1..4  result data.
REQ-007 out_respN  output  2 ([0:1]) per port N=1..4  response: 0 none, 1 success, 2 error, 3 never driven.

Function
REQ-008 The four ports SHALL be independent identical channels with no shared state or arbitration.
REQ-009 Commands: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; every other code (3, 4, 7-15) SHALL be invalid.
REQ-010 Each channel SHALL have states IDLE and OP2: IDLE with cmd!=0 at edge E1 latches cmd and operand 1, goes to OP2; OP2 at edge E2 latches operand 2, computes, returns to IDLE.
REQ-011 In OP2 the cmd input SHALL be ignored; data_in is operand 2 only.
REQ-012 At E2 out_data/out_resp SHALL be registered with the result; they SHALL hold for exactly one cycle and return to resp=0, data=0 at the next edge.
REQ-013 A new command MAY be presented in the cycle immediately after E2 (back-to-back, one result per two cycles).
REQ-014 Add: 33-bit sum; carry out SHALL give resp=2, data=0; else resp=1, data=sum[31:0].
REQ-015 Subtract: op2 > op1 (unsigned) SHALL give resp=2, data=0; else resp=1, data=op1-op2.
REQ-016 Shift left/right: op1 shifted logically by op2[4:0] (low 5 bits of operand 2), zero-fill, resp=1; bits shifted out are discarded, no error.
REQ-017 Invalid command SHALL still consume the operand-2 cycle and respond resp=2, data=0 at E2.
REQ-018 When no result is due, outputs SHALL be resp=0, data=0.

Reset
REQ-019 reset[1]=0 at a rising edge SHALL force every channel to IDLE, clear latched cmd/operands, and drive all out_data=0, out_resp=0 from that edge.
REQ-020 Reset asserted mid-operation (in OP2) SHALL abort it with no response produced.
REQ-021 While reset[1]=0, all request inputs SHALL be ignored; first command is accepted at the first edge with reset[1]=1.

Configuration
REQ-022 Macro CALC1_SHIFT_EN: when defined, commands 5 and 6 SHALL behave per REQ-016; when undefined, shift logic SHALL be absent and commands 5 and 6 SHALL be treated as invalid per REQ-017.

Verification
REQ-023 Port1 cmd=1 op1=0x00000001, op2=0x01FFFFFF -> resp=1, data=0x02000000 for one cycle; then resp=0.
REQ-024 Port1 cmd=1 op1=0xFFFFFFFF, op2=0x00000001 -> resp=2, data=0; also 0x1FFFFFFF+0x1FFFFFFF -> resp=1, data=0x3FFFFFFE.
REQ-025 Port1 cmd=2 op1=0x1, op2=0xF -> resp=2, data=0; cmd=2 op1=0xF, op2=0x1 -> resp=1, data=0xE.
REQ-026 Port1 cmd=3 and cmd=4 (op1=1, op2=0) -> resp=2, data=0 each.
REQ-027 Walking ones: add 2^k+0 for k=0..30 -> data=2^k; shift left 2^k by 1 for k=0..29 -> data=2^(k+1); all four ports driven simultaneously with distinct values -> each port returns its own result.
REQ-028 reset[1]=0 asserted during OP2 -> no response, outputs 0; next command after reset release completes normally.
